instr_encoder: RTL
==================

# instr_encoder

Sequential instruction encoder and program loader for the single-cycle R/I-type CPU. It is the inverse of the control decoder: it takes symbolic requests (instruction kind, 4-bit ALU operation code, register numbers, immediate) over a valid/ready handshake. It packs each request into a 32-bit MIPS machine word that the CPU's decoder maps back to the same ALU code, and writes the words to consecutive instruction-memory addresses. It sits between the test/boot host and the instruction RAM write port.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous restart: write pointer to 0, clears full and err_cnt
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready
- kind  in  3  0 R-type ALU, 1 I-type ALU, 2 lw, 3 sw, 4-7 illegal
- alu_op  in  4  ALU operation code, in the decoder's encoding
- rs, rt, rd  in  5 each  register numbers; rd ignored for kind 1-3
- imm  in  16  immediate / offset; ignored for kind 0
- mem_we  out  1  one-cycle instruction-RAM write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- full  out  1  all DEPTH words written
- err  out  1  one-cycle pulse: accepted request was illegal
- err_cnt  out  8  saturating count of illegal requests
- count  out  ADDR_W+1  number of words written since reset/clr

## Operation
- Encoding, R-type (kind 0): word = {6'b000000, rs, rt, rd, 5'b00000, func}; alu_op->func: 0100->100000 (add), 0101->100010 (sub), 0000->100100 (and), 0001->100101 (or), 0010->100110 (xor), 0011->100111 (nor), 0110->101011 (sltu), 0111->000100 (sllv); any other alu_op is illegal.
- I-type ALU (kind 1): word = {op, rs, rt, imm}; alu_op->op: 0100->001000 (addi), 0000->001100 (andi), 0010->001110 (xori), 0110->001011 (sltiu); others illegal.
- kind 2: op 100011 (lw); kind 3: op 101011 (sw); alu_op ignored and must not make the request illegal.
- FSM states: IDLE, WRITE, FULL.
- IDLE: req_ready=1. On handshake: if legal, register word into wdata_r and go to WRITE; if illegal, pulse err next cycle, err_cnt+1 (saturate at 255), stay IDLE, nothing written.
- WRITE: req_ready=0, mem_we=1, mem_addr=ptr, mem_wdata=wdata_r; ptr+1, count+1. Go to FULL if count reaches DEPTH, else IDLE.
- FULL: req_ready=0, full=1, mem_we=0; leaves only on clr or reset.
- clr in IDLE or FULL: ptr=0, count=0, err_cnt=0, state IDLE; a handshake in the same cycle is ignored (clr has priority, req_ready forced 0 while clr=1).
- clr in WRITE: the pending write still completes that cycle; ptr, count and err_cnt end at 0, state IDLE.
- Pointer wrap is impossible: FULL is entered after address DEPTH-1 is written, and ptr is then held.

## Timing
- Reset values: state IDLE, ptr 0, count 0, err_cnt 0, err 0, full 0, mem_we 0, mem_addr 0, mem_wdata 0; req_ready 0 while rst_n low.
- Reset mid-WRITE aborts the write: mem_we drops asynchronously and no word is committed.
- Latency: handshake at edge N -> mem_we high for exactly cycle N+1 with the word; req_ready low during N+1, high again at N+2 unless FULL.
- Throughput: one instruction per 2 cycles. Illegal requests: 1 cycle; err pulses during cycle N+1.
- mem_addr and mem_wdata are stable and valid only while mem_we=1; they hold their last value otherwise.
- full rises in the cycle after the last write, and count = DEPTH at that point.

## Test plan
- Reset, then request kind 0, alu_op 0100, rs 1, rt 2, rd 3 -> mem_we one cycle, addr 0, wdata 0x00221820.
- kind 1, alu_op 0110, rs 4, rt 5, imm 0xFFFF, then kind 3, rs 29, rt 8, imm 0x0010 -> wdata 0x2C85FFFF at addr 0, then 0xAFA80010 at addr 1; req_ready low during each write cycle.
- kind 0 with alu_op 1000, then kind 6 -> no mem_we, err pulse twice, err_cnt 2, count unchanged. Next legal request is written at the unchanged address.
- ADDR_W=2: 4 legal requests -> addresses 0..3, full=1, count 4, req_ready 0. A fifth req_valid is held unaccepted. clr -> IDLE, next write at addr 0.
- clr asserted in the same cycle as a WRITE -> write still completes at its address, then count 0. clr asserted with req_valid in IDLE -> no acceptance.
- rst_n pulsed low asynchronously during WRITE -> mem_we drops immediately and all outputs are at their reset values before the next edge.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-RAM write bus of the instruction encoder.
// master = host/RAM side, slave = the encoder itself.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        kind;
    logic [3:0]        alu_op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, kind, alu_op, rs, rt, rd, imm,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, kind, alu_op, rs, rt, rd, imm,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic R/I-type requests into MIPS words and writes them to
// consecutive instruction-RAM addresses; illegal requests are counted, not written.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    instr_encoder_if.slave       bus,
    output logic                 full,
    output logic                 err,
    output logic [7:0]           err_cnt,
    output logic [ADDR_W:0]      count
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       wdata_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [7:0]        err_cnt_reg;
    logic              err_reg;

    logic              handshake;
    logic              legal;
    logic [31:0]       word;
    logic [5:0]        func;
    logic [5:0]        opcode;

    assign bus.req_ready = rst_n && !clr && (state_reg == IDLE);
    assign handshake     = bus.req_valid && bus.req_ready;

    always_comb begin
        legal  = 1'b1;
        func   = 6'b000000;
        opcode = 6'b000000;
        word   = 32'h0000_0000;
        case (bus.kind)
            3'd0: begin
                case (bus.alu_op)
                    4'b0100: func = 6'b100000;
                    4'b0101: func = 6'b100010;
                    4'b0000: func = 6'b100100;
                    4'b0001: func = 6'b100101;
                    4'b0010: func = 6'b100110;
                    4'b0011: func = 6'b100111;
                    4'b0110: func = 6'b101011;
                    4'b0111: func = 6'b000100;
                    default: legal = 1'b0;
                endcase
                word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, func};
            end
            3'd1: begin
                case (bus.alu_op)
                    4'b0100: opcode = 6'b001000;
                    4'b0000: opcode = 6'b001100;
                    4'b0010: opcode = 6'b001110;
                    4'b0110: opcode = 6'b001011;
                    default: legal = 1'b0;
                endcase
                word = {opcode, bus.rs, bus.rt, bus.imm};
            end
            3'd2:    word = {6'b100011, bus.rs, bus.rt, bus.imm};
            3'd3:    word = {6'b101011, bus.rs, bus.rt, bus.imm};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!clr && handshake && legal) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (clr) begin
                    state_next = IDLE;
                end else if (count_reg == (ADDR_W + 1)'(DEPTH - 1)) begin
                    state_next = FULL;
                end else begin
                    state_next = IDLE;
                end
            end
            FULL: begin
                if (clr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The word count doubles as the write pointer; it stops at DEPTH so no wrap occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_reg   <= 32'h0000_0000;
            addr_reg    <= '0;
            count_reg   <= '0;
            err_cnt_reg <= 8'd0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (clr) begin
                count_reg   <= '0;
                err_cnt_reg <= 8'd0;
            end else begin
                if (state_reg == WRITE) begin
                    count_reg <= count_reg + (ADDR_W + 1)'(1);
                end
                if (handshake && legal) begin
                    wdata_reg <= word;
                    addr_reg  <= count_reg[ADDR_W-1:0];
                end
                if (handshake && !legal) begin
                    err_reg <= 1'b1;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.mem_we    = (state_reg == WRITE);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign full          = (state_reg == FULL);
    assign err           = err_reg;
    assign err_cnt       = err_cnt_reg;
    assign count         = count_reg;
endmodule
